eth_fcs_append: RTL and testbench

- Downstream framing stage for the 32-bit CRC datapath.
- Accepts a frame as a stream of 32-bit words with valid/ready, last and byte-keep.
- Computes the Ethernet CRC32 over all frame bytes and emits the frame unchanged, followed by the 4-byte FCS packed contiguously after the last data byte.
- Sits between the packet builder and the MAC TX word interface.

---
 rtl/eth_fcs_pkg.sv | 33 +++
 rtl/crc32_word_update.sv | 22 ++
 rtl/eth_fcs_append.sv | 169 ++++++++++++++++
 tb/tb_eth_fcs_append.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_fcs_pkg.sv
// Shared CRC-32 constants, framing state type and the bytewise reflected CRC-32 step
// used by the Ethernet FCS append stage.
package eth_fcs_pkg;

    function automatic logic [31:0] reflect32(input logic [31:0] value);
        logic [31:0] result;
        for (int i = 0; i < 32; i++) begin
            result[i] = value[31-i];
        end
        return result;
    endfunction

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } state_e;

    // Reflected CRC: the byte enters LSB-first, so the register shifts right.
    function automatic logic [31:0] crc32_byte(input logic [7:0] data, input logic [31:0] crc);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational CRC-32 update over the first 1-4 bytes of a 32-bit word;
// byte 0 sits in [7:0] and is processed first, unused stages are bypassed.
module crc32_word_update
    import eth_fcs_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] crc_out
);

    logic [31:0] chain [0:4];

    assign chain[0] = crc_in;

    for (genvar i = 0; i < 4; i++) begin : g_stage
        assign chain[i+1] = (nbytes > 3'(i)) ? crc32_byte(data[8*i +: 8], chain[i]) : chain[i];
    end

    assign crc_out = chain[4];

endmodule

// File: rtl/eth_fcs_append.sv
// Appends the Ethernet FCS to a 32-bit valid/ready word stream, packing it right after
// the last data byte. Optional frame counter port enabled by ETH_FCS_FRAME_CNT_EN.
module eth_fcs_append
    import eth_fcs_pkg::*;
#(
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] XOR_OUT = CRC32_XOROUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic [3:0]  s_keep,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready
`ifdef ETH_FCS_FRAME_CNT_EN
    ,
    output logic [31:0] frame_cnt
`endif
);

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] m_data_q, m_data_d;
    logic [3:0]  m_keep_q, m_keep_d;
    logic        m_last_q, m_last_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] tail_data_q, tail_data_d;
    logic [3:0]  tail_keep_q, tail_keep_d;

    logic        out_free;
    logic [3:0]  keep_eff;
    logic [2:0]  nbytes;
    logic [31:0] data_mask;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [63:0] packed_last;

    assign out_free = !m_valid_q || m_ready;
    assign s_ready  = out_free && (state_q == DATA) && !rst;

    // Only a contiguous-from-lane-0 keep on the last word is honoured; anything else is a full word.
    always_comb begin
        keep_eff = 4'hF;
        if (s_last) begin
            case (s_keep)
                4'b0001, 4'b0011, 4'b0111: keep_eff = s_keep;
                default:                   keep_eff = 4'hF;
            endcase
        end
    end

    always_comb begin
        case (keep_eff)
            4'b0001: nbytes = 3'd1;
            4'b0011: nbytes = 3'd2;
            4'b0111: nbytes = 3'd3;
            default: nbytes = 3'd4;
        endcase
    end

    assign data_mask = {{8{keep_eff[3]}}, {8{keep_eff[2]}}, {8{keep_eff[1]}}, {8{keep_eff[0]}}};

    crc32_word_update u_crc (
        .crc_in  (crc_q),
        .data    (s_data),
        .nbytes  (nbytes),
        .crc_out (crc_next)
    );

    assign fcs = crc_next ^ XOR_OUT;

    // Low word is the last data beat with leading FCS bytes; high word is the tail beat.
    assign packed_last = {32'h0, s_data & data_mask} | ({32'h0, fcs} << {nbytes, 3'b000});

    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        tail_data_d = tail_data_q;
        tail_keep_d = tail_keep_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            DATA: begin
                if (s_valid && s_ready) begin
                    m_valid_d = 1'b1;
                    m_keep_d  = 4'hF;
                    m_last_d  = 1'b0;
                    if (s_last) begin
                        m_data_d    = packed_last[31:0];
                        tail_data_d = packed_last[63:32];
                        tail_keep_d = keep_eff;
                        crc_d       = INIT;
                        state_d     = TAIL;
                    end else begin
                        m_data_d = s_data;
                        crc_d    = crc_next;
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = tail_data_q;
                    m_keep_d  = tail_keep_q;
                    m_last_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            default: state_d = DATA;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DATA;
            crc_q       <= INIT;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            tail_data_q <= '0;
            tail_keep_q <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
            tail_data_q <= tail_data_d;
            tail_keep_q <= tail_keep_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

`ifdef ETH_FCS_FRAME_CNT_EN
    logic [31:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (m_valid_q && m_ready && m_last_q) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_eth_fcs_append.sv
// Directed and randomised-stall bench for eth_fcs_append: known CRC vectors,
// back-to-back frames, keep handling, mid-frame reset and the optional frame counter.
module tb_eth_fcs_append;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b1;
`ifdef ETH_FCS_FRAME_CNT_EN
    logic [31:0] frame_cnt;
`endif

    int    total = 0;
    int    bad = 0;
    bit    rand_ready = 1'b0;
    beat_t rx_q[$];
    beat_t exp_in[$];
    beat_t exp_out[$];

    eth_fcs_append dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef ETH_FCS_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records accepted beats and checks hold-stability under backpressure.
    initial begin
        beat_t held;
        bit    stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && m_valid) begin
                    total++;
                    if ({m_data, m_keep, m_last} !== held) begin
                        bad++;
                        $display("FAIL stall_hold: got %h/%b/%b want %h/%b/%b",
                                 m_data, m_keep, m_last, held.d, held.k, held.l);
                    end
                end
                if (m_valid && m_ready) rx_q.push_back({m_data, m_keep, m_last});
                stalled = m_valid && !m_ready;
                held    = {m_data, m_keep, m_last};
            end
        end
    end

    function automatic logic [31:0] ref_fcs(input logic [7:0] bytes[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (bytes[i]) begin
            c ^= {24'h0, bytes[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic pack_words(input logic [7:0] bytes[$], output beat_t words[$]);
        int n;
        n = bytes.size();
        words.delete();
        for (int i = 0; i < n; i += 4) begin
            beat_t w;
            int    rem;
            rem = n - i;
            w.d = '0;
            for (int j = 0; j < 4 && j < rem; j++) w.d[8*j +: 8] = bytes[i+j];
            w.k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            w.l = (rem <= 4);
            words.push_back(w);
        end
    endtask

    task automatic add_frame(input logic [7:0] bytes[$]);
        beat_t       win[$];
        beat_t       wout[$];
        logic [7:0]  stream[$];
        logic [31:0] f;
        f      = ref_fcs(bytes);
        stream = bytes;
        for (int j = 0; j < 4; j++) stream.push_back(f[8*j +: 8]);
        pack_words(bytes, win);
        pack_words(stream, wout);
        foreach (win[i]) exp_in.push_back(win[i]);
        foreach (wout[i]) exp_out.push_back(wout[i]);
    endtask

    task automatic send_beats();
        foreach (exp_in[i]) begin
            int guard;
            bit hs;
            guard   = 0;
            hs      = 1'b0;
            s_data  = exp_in[i].d;
            s_keep  = exp_in[i].k;
            s_last  = exp_in[i].l;
            s_valid = 1'b1;
            while (!hs && guard < 1000) begin
                @(negedge clk);
                hs = s_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            total++;
            if (!hs) begin
                bad++;
                $display("FAIL send_timeout: beat %0d not accepted, got s_ready=0 want 1", i);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_keep  = '0;
    endtask

    task automatic wait_rx(input int n, input string name);
        int guard;
        guard = 0;
        while (rx_q.size() < n && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (rx_q.size() != n) begin
            bad++;
            $display("FAIL %s_count: got %0d beats want %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        rx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_valid, m_data, m_keep, m_last, s_ready} !== 39'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h k=%b l=%b rdy=%b want all 0",
                     m_valid, m_data, m_keep, m_last, s_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got s_ready=%b want 1", s_ready);
        end
        @(posedge clk);
        #1;
        rx_q.delete();
    endtask

    task automatic test_crc_123456789();
        beat_t want[4];
        want[0] = {32'h34333231, 4'hF, 1'b0};
        want[1] = {32'h38373635, 4'hF, 1'b0};
        want[2] = {32'hF4392639, 4'hF, 1'b0};
        want[3] = {32'h000000CB, 4'h1, 1'b1};
        exp_in.delete();
        exp_in.push_back({32'h34333231, 4'hF, 1'b0});
        exp_in.push_back({32'h38373635, 4'hF, 1'b0});
        exp_in.push_back({32'h00000039, 4'h1, 1'b1});
        send_beats();
        wait_rx(4, "crc_123456789");
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== want[i]) begin
                bad++;
                $display("FAIL crc_123456789 beat %0d: got %h/%b/%b want %h/%b/%b", i,
                         rx_q[i].d, rx_q[i].k, rx_q[i].l, want[i].d, want[i].k, want[i].l);
            end
        end
        rx_q.delete();
    endtask

    task automatic test_crc_abcd();
        beat_t want[2];
        want[0] = {32'h64636261, 4'hF, 1'b0};
        want[1] = {32'hED82CD11, 4'hF, 1'b1};
        exp_in.delete();
        exp_in.push_back({32'h64636261, 4'hF, 1'b1});
        send_beats();
        wait_rx(2, "crc_abcd");
        for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== want[i]) begin
                bad++;
                $display("FAIL crc_abcd beat %0d: got %h/%b/%b want %h/%b/%b", i,
                         rx_q[i].d, rx_q[i].k, rx_q[i].l, want[i].d, want[i].k, want[i].l);
            end
        end
        rx_q.delete();
    endtask

    task automatic test_back_to_back();
        beat_t want[4];
        want[0] = {32'h64636261, 4'hF, 1'b0};
        want[1] = {32'hED82CD11, 4'hF, 1'b1};
        want[2] = {32'h64636261, 4'hF, 1'b0};
        want[3] = {32'hED82CD11, 4'hF, 1'b1};
        exp_in.delete();
        exp_in.push_back({32'h64636261, 4'hF, 1'b1});
        exp_in.push_back({32'h64636261, 4'hF, 1'b1});
        send_beats();
        wait_rx(4, "back_to_back");
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== want[i]) begin
                bad++;
                $display("FAIL back_to_back beat %0d: got %h/%b/%b want %h/%b/%b", i,
                         rx_q[i].d, rx_q[i].k, rx_q[i].l, want[i].d, want[i].k, want[i].l);
            end
        end
        rx_q.delete();
    endtask

    // Keep is ignored on non-last words; a non-contiguous last keep counts as a full word.
    task automatic test_keep_handling();
        beat_t want[6];
        want[0] = {32'h34333231, 4'hF, 1'b0};
        want[1] = {32'h38373635, 4'hF, 1'b0};
        want[2] = {32'hF4392639, 4'hF, 1'b0};
        want[3] = {32'h000000CB, 4'h1, 1'b1};
        want[4] = {32'h64636261, 4'hF, 1'b0};
        want[5] = {32'hED82CD11, 4'hF, 1'b1};
        exp_in.delete();
        exp_in.push_back({32'h34333231, 4'h0, 1'b0});
        exp_in.push_back({32'h38373635, 4'h5, 1'b0});
        exp_in.push_back({32'h00000039, 4'h1, 1'b1});
        exp_in.push_back({32'h64636261, 4'h5, 1'b1});
        send_beats();
        wait_rx(6, "keep_handling");
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== want[i]) begin
                bad++;
                $display("FAIL keep_handling beat %0d: got %h/%b/%b want %h/%b/%b", i,
                         rx_q[i].d, rx_q[i].k, rx_q[i].l, want[i].d, want[i].k, want[i].l);
            end
        end
        rx_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        beat_t want[4];
        want[0] = {32'h34333231, 4'hF, 1'b0};
        want[1] = {32'h38373635, 4'hF, 1'b0};
        want[2] = {32'hF4392639, 4'hF, 1'b0};
        want[3] = {32'h000000CB, 4'h1, 1'b1};
        exp_in.delete();
        exp_in.push_back({32'h11111111, 4'hF, 1'b0});
        exp_in.push_back({32'h22222222, 4'hF, 1'b0});
        send_beats();
        pulse_reset();
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (rx_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_frame_idle: got %0d beats want 0", rx_q.size());
        end
        exp_in.delete();
        exp_in.push_back({32'h34333231, 4'hF, 1'b0});
        exp_in.push_back({32'h38373635, 4'hF, 1'b0});
        exp_in.push_back({32'h00000039, 4'h1, 1'b1});
        send_beats();
        wait_rx(4, "reset_mid_frame");
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== want[i]) begin
                bad++;
                $display("FAIL reset_mid_frame beat %0d: got %h/%b/%b want %h/%b/%b", i,
                         rx_q[i].d, rx_q[i].k, rx_q[i].l, want[i].d, want[i].k, want[i].l);
            end
        end
        rx_q.delete();
    endtask

    task automatic test_random_stall();
        exp_in.delete();
        exp_out.delete();
        for (int f = 0; f < 100; f++) begin
            logic [7:0] bytes[$];
            int         len;
            len = $urandom_range(1, 64);
            for (int j = 0; j < len; j++) bytes.push_back(8'($urandom_range(0, 255)));
            add_frame(bytes);
        end
        rand_ready = 1'b1;
        send_beats();
        wait_rx(exp_out.size(), "random_stall");
        rand_ready = 1'b0;
        for (int i = 0; i < exp_out.size() && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_out[i]) begin
                bad++;
                $display("FAIL random_stall beat %0d: got %h/%b/%b want %h/%b/%b", i,
                         rx_q[i].d, rx_q[i].k, rx_q[i].l, exp_out[i].d, exp_out[i].k, exp_out[i].l);
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rx_q.delete();
    endtask

`ifdef ETH_FCS_FRAME_CNT_EN
    task automatic test_frame_cnt();
        pulse_reset();
        exp_in.delete();
        for (int f = 0; f < 5; f++) exp_in.push_back({32'h64636261, 4'hF, 1'b1});
        send_beats();
        wait_rx(10, "frame_cnt");
        total++;
        if (frame_cnt !== 32'd5) begin
            bad++;
            $display("FAIL frame_cnt_five: got %0d want 5", frame_cnt);
        end
        pulse_reset();
        @(negedge clk);
        total++;
        if (frame_cnt !== 32'd0) begin
            bad++;
            $display("FAIL frame_cnt_reset: got %0d want 0", frame_cnt);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_crc_123456789();
        test_crc_abcd();
        test_back_to_back();
        test_keep_handling();
        test_reset_mid_frame();
        test_random_stall();
`ifdef ETH_FCS_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
